// File: rtl/clz_seq.sv
// Sequential leading-zero counter: one 16-bit CLZ unit is time-shared across
// the operand's 16-bit slices, scanning MSB slice first.

module clz16 (
    input  logic [15:0] i_data,
    output logic [3:0]  o_count
);
    // Lowest set bit is overwritten by higher ones; all-zero input yields 15.
    always_comb begin
        o_count = 4'd15;
        for (int i = 0; i < 16; i++) begin
            if (i_data[i]) o_count = 4'(15 - i);
        end
    end
endmodule

// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload stable while valid is high and not yet
// accepted.
module clz_seq #(
    parameter int NSLICE = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [16*NSLICE-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [6:0]           o_count,
    output logic                 o_zero,
    output logic                 o_busy,
    output logic [1:0]           o_dbg_state
);
    localparam int W = 16 * NSLICE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [W-1:0] opnd_q, opnd_d;
    logic         valid_q, valid_d;
    logic [6:0]   count_q, count_d;
    logic         zero_q, zero_d;

    logic [15:0]  slice;
    logic [3:0]   slice_clz;
    logic         slice_nz;

    always_comb begin
        slice = 16'd0;
        for (int s = 0; s < NSLICE; s++) begin
            if (idx_q == 2'(s)) slice = opnd_q[W-1-16*s -: 16];
        end
    end

    assign slice_nz = |slice;

    clz16 u_clz16 (
        .i_data  (slice),
        .o_count (slice_clz)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opnd_d  = opnd_q;
        valid_d = valid_q;
        count_d = count_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (i_valid) begin
                    opnd_d  = i_data;
                    idx_d   = 2'd0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (slice_nz) begin
                    // idx occupies bits [5:4], so this is 16*idx + clz.
                    count_d = {1'b0, idx_q, slice_clz};
                    zero_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else if (idx_q == 2'(NSLICE - 1)) begin
                    count_d = 7'(W);
                    zero_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            opnd_q  <= '0;
            valid_q <= 1'b0;
            count_q <= 7'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opnd_q  <= opnd_d;
            valid_q <= valid_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_valid     = valid_q;
    assign o_count     = count_q;
    assign o_zero      = zero_q;
    assign o_dbg_state = state_q;
endmodule

// File: tb/tb_clz_seq.sv
// Self-checking bench for clz_seq (NSLICE=4): directed corner cases, reset
// abandonment, back-to-back transfers and randomized operands vs a bit-scan model.

module tb_clz_seq;
    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [6:0]  o_count;
    logic        o_zero;
    logic        o_busy;
    logic [1:0]  o_dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_q[$];

    clz_seq #(.NSLICE(4)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_count     (o_count),
        .o_zero      (o_zero),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int clz_ref(input logic [63:0] d);
        for (int i = 63; i >= 0; i--) begin
            if (d[i]) return 63 - i;
        end
        return 64;
    endfunction

    // Result appears once the first nonzero 16-bit slice has been scanned.
    function automatic int lat_ref(input int cnt);
        if (cnt >= 64) return 4;
        return cnt / 16 + 1;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [63:0] d, input int hold);
        int         lat;
        int         exp_c;
        logic [6:0] e;
        exp_c = clz_ref(d);
        exp_q.push_back(7'(exp_c));
        check("ready_before_op", o_ready, 1);
        i_valid = 1'b1;
        i_data  = d;
        i_ready = 1'b0;
        tick();
        lat = 0;
        i_valid = 1'($urandom_range(0, 1));
        i_data  = {$urandom, $urandom};
        while (!o_valid && lat < 10) begin
            tick();
            lat++;
            i_data = {$urandom, $urandom};
        end
        e = exp_q.pop_front();
        check("latency", 64'(lat), 64'(lat_ref(exp_c)));
        check("count", o_count, e);
        check("zero", o_zero, (e == 7'd64));
        check("busy_done", o_busy, 1);
        check("ready_done", o_ready, 0);
        repeat (hold) begin
            i_valid = 1'($urandom_range(0, 1));
            i_data  = {$urandom, $urandom};
            tick();
            check("hold_valid", o_valid, 1);
            check("hold_count", o_count, e);
            check("hold_zero", o_zero, (e == 7'd64));
            check("hold_ready", o_ready, 0);
            check("hold_busy", o_busy, 1);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("post_valid", o_valid, 0);
        check("post_ready", o_ready, 1);
        check("post_busy", o_busy, 0);
        check("post_count_kept", o_count, e);
        check("post_zero_kept", o_zero, (e == 7'd64));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] ops[2];
        logic [63:0] r;
        int          sent;
        int          pulses;
        logic        prev_valid;
        logic        acc;
        logic [6:0]  e;

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        #2;
        check("rst_async_valid", o_valid, 0);
        check("rst_async_ready", o_ready, 1);
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_count", o_count, 0);
        check("rst_zero", o_zero, 0);
        check("rst_busy", o_busy, 0);

        // Directed corners
        do_op(64'h8000_0000_0000_0000, 0);
        do_op(64'h0000_0000_0001_0000, 1);
        do_op(64'h0000_0000_0000_0001, 0);
        do_op(64'h0000_0000_0000_0000, 2);
        do_op(64'h0000_0123_4567_89AB, 5);

        // Reset during SCAN of an all-zero operand
        i_valid = 1'b1;
        i_data  = 64'h0;
        tick();
        i_valid = 1'b0;
        tick();
        check("scan_busy", o_busy, 1);
        i_rst = 1'b1;
        #1;
        check("midrst_busy", o_busy, 0);
        check("midrst_valid", o_valid, 0);
        check("midrst_count", o_count, 0);
        tick();
        i_rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("afterrst_valid", o_valid, 0);
            check("afterrst_ready", o_ready, 1);
        end
        do_op(64'h00F0_0000_0000_0000, 0);

        // Back-to-back with i_ready held high
        ops[0] = 64'h0000_8000_0000_0000;
        ops[1] = 64'h0000_0000_0000_0001;
        exp_q.push_back(7'(clz_ref(ops[0])));
        exp_q.push_back(7'(clz_ref(ops[1])));
        sent = 0;
        pulses = 0;
        prev_valid = 1'b0;
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = ops[0];
        for (int c = 0; c < 20; c++) begin
            acc = o_ready && i_valid;
            tick();
            if (acc) begin
                sent++;
                if (sent < 2) i_data = ops[sent];
                else i_valid = 1'b0;
            end
            if (o_valid) begin
                pulses++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7f;
                check("b2b_count", o_count, e);
                check("b2b_single_pulse", prev_valid, 0);
            end else if (prev_valid) begin
                check("b2b_idle_between", o_ready, 1);
            end
            prev_valid = o_valid;
        end
        i_ready = 1'b0;
        check("b2b_pulses", 64'(pulses), 2);
        check("b2b_q_empty", 64'(exp_q.size()), 0);

        // Randomized operands with varied leading-zero depth
        for (int n = 0; n < 40; n++) begin
            r = {$urandom, $urandom} | 64'h1;
            r = r >> $urandom_range(0, 64);
            do_op(r, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clz_seq.md
CLZ_SEQ -- requirements
Module: clz_seq

Interface
REQ-001 SHALL provide parameter NSLICE, default 4, meaning the number of 16-bit slices in the operand (legal 1..4; operand width W = 16*NSLICE).
REQ-002 SHALL provide port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port i_rst  input  1  the reset; asynchronous, active-high.
REQ-004 SHALL provide port i_valid  input  1  the operand-valid request.
REQ-005 SHALL provide port o_ready  output  1  the controller-can-accept signal.
REQ-006 SHALL provide port i_data  input  W  the operand, MSB = bit W-1.
REQ-007 SHALL provide port o_valid  output  1  the result-valid signal.
REQ-008 SHALL provide port i_ready  input  1  the consumer-accepts-result signal.
REQ-009 SHALL provide port o_count  output  7  the leading-zero count of the operand, range 0..W.
REQ-010 SHALL provide port o_zero  output  1  operand-was-all-zeros flag.
REQ-011 SHALL provide port o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL instantiate exactly one 16-bit CLZ unit (16-bit in, 0..15 out) and time-share it across slices; no other leading-zero logic permitted.
REQ-013 SHALL implement the FSM states IDLE, SCAN and DONE, encoded in a 2-bit registered state.
REQ-014 IDLE: o_ready=1; when i_valid&&o_ready at an edge, SHALL latch i_data into an operand register, clear slice index idx to 0, and go to SCAN.
REQ-015 SCAN: o_ready=0; SHALL present slice idx (bits W-1-16*idx down to W-16-16*idx, MSB-first) to the CLZ unit each cycle.
REQ-016 SCAN, slice nonzero: SHALL register o_count = 16*idx + CLZ result, o_zero=0, and go to DONE.
REQ-017 SCAN, slice zero, idx<NSLICE-1: SHALL increment idx and remain in SCAN; the CLZ result SHALL be ignored (the unit returns 15 for an all-zero input).
REQ-018 SCAN, slice zero, idx=NSLICE-1: SHALL register o_count=W, o_zero=1, and go to DONE.
REQ-019 Latency SHALL be j+1 edges from the acceptance edge to o_valid high, where j = index of the first nonzero slice; all-zero operand: NSLICE edges.
REQ-020 DONE: o_valid=1, o_ready=0; o_count/o_zero SHALL hold stable until o_valid&&i_ready, then the FSM SHALL go to IDLE (no same-cycle accept of a new operand).
REQ-021 o_valid SHALL be registered and high only in DONE.
REQ-022 After a result handshake, o_count/o_zero SHALL retain their values until the next result is registered.
REQ-023 Changes on i_data or i_valid during SCAN/DONE SHALL have no effect.
REQ-024 o_busy SHALL equal (state != IDLE).

Reset
REQ-025 While i_rst=1, SHALL force state=IDLE, idx=0, operand register=0, o_valid=0, o_count=0, o_zero=0, independent of i_clk.
REQ-026 Reset asserted mid-SCAN or in DONE SHALL abandon the operation with no o_valid pulse; o_ready=1 from the first cycle after deassertion.
REQ-027 All outputs SHALL be X-free from the first cycle after reset deassertion.

Verification (NSLICE=4)
REQ-028 i_data=64'h8000_0000_0000_0000 -> o_valid 1 edge after accept, o_count=0, o_zero=0.
REQ-029 i_data=64'h0000_0000_0001_0000 -> o_valid 3 edges after accept, o_count=47, o_zero=0.
REQ-030 i_data=64'h0000_0000_0000_0001 -> o_count=63 after 4 edges; i_data=0 -> o_count=64, o_zero=1 after 4 edges.
REQ-031 Backpressure: hold i_ready=0 for 5 cycles in DONE and toggle i_data/i_valid -> o_valid, o_count, o_zero stable, o_ready=0, o_busy=1; release -> IDLE next edge.
REQ-032 Assert i_rst during SCAN of operand 0 -> no o_valid; after release, accept 64'h00F0_0000_0000_0000 -> o_count=8 after 1 edge.
REQ-033 Back-to-back: two operands (64'h0000_8000_0000_0000, then 64'h1) with i_ready=1 -> counts 16 then 63, exactly one o_valid cycle each, idle cycle between.
